// File: rtl/dmem_responder_if.sv
// Data-memory port bundle: request and response valid/ready channels.
// master = load/store unit side, slave = memory responder side.
interface dmem_responder_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [15:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder over a 16-bit register-array RAM.
// Optional fault detection enabled by defining DMEM_ERR_EN.
module dmem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int IW = ADDR_W - 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [15:0]       rdata_q;
   logic [15:0]       mem_q [DEPTH];

   logic              accept;
   logic              enter_resp;
   logic              eff_write;
   logic [ADDR_W-1:0] eff_addr;
   logic [15:0]       eff_wdata;
   logic [IW-1:0]     eff_idx;
   logic [AW-1:0]     widx;
   logic              acc_err;

   // With zero wait states the RESP entry edge is the accept edge,
   // so the live request is used; otherwise the latched copy.
   always_comb begin
      eff_write = write_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         eff_write = bus.req_write;
         eff_addr  = bus.req_addr;
         eff_wdata = bus.req_wdata;
      end
   end

   assign eff_idx = eff_addr[ADDR_W-1:1];

`ifdef DMEM_ERR_EN
   logic err_q;

   assign acc_err = eff_addr[0] | (eff_idx >= IW'(DEPTH));
   assign widx    = AW'(eff_idx);

   // Fault flag captured on RESP entry, held through the response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (enter_resp) begin
         err_q <= acc_err;
      end
   end

   assign bus.rsp_err = err_q;
`else
   logic unused_lsb;

   assign unused_lsb  = eff_addr[0];
   assign acc_err     = 1'b0;
   assign widx        = AW'(eff_idx % IW'(DEPTH));
   assign bus.rsp_err = 1'b0;
`endif

   // Next-state logic: accept in IDLE, count down wait states,
   // release on the response handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d    = S_RESP;
               cnt_d      = 4'd0;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request on the accept edge; later input changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
      end else if (accept) begin
         write_q <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   // Load data sampled on RESP entry; zero for stores and faults.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 16'h0000;
      end else if (enter_resp) begin
         if (!eff_write && !acc_err) begin
            rdata_q <= mem_q[widx];
         end else begin
            rdata_q <= 16'h0000;
         end
      end
   end

   // RAM array: cleared on reset, store commits on RESP entry only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 16'h0000;
         end
      end else if (enter_resp && eff_write && !acc_err) begin
         mem_q[widx] <= eff_wdata;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder.
// Reference model: plain word array with wrap/fault rules.
module tb_dmem_responder;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 32;
   parameter  int W      = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_responder #(
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_acc = -100;
   int prev_hold;
   logic [15:0] model [DEPTH];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_err(input logic [7:0] a);
`ifdef DMEM_ERR_EN
      return (a[0] == 1'b1) || ((int'(a) / 2) >= DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [7:0] a);
      return (int'(a) / 2) % DEPTH;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
   endtask

   task automatic accept_req(input logic wr, input logic [7:0] a,
                             input logic [15:0] wd);
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = 16'($urandom);
   endtask

   task automatic txn(input logic wr, input logic [7:0] a,
                      input logic [15:0] wd, input int hold,
                      input bit poke, input bit b2b);
      int lat;
      logic ee;
      logic [15:0] er;
      logic [15:0] held;
      accept_req(wr, a, wd);
      if (b2b) check("accept_spacing", 32'(cyc - last_acc), 32'(W + 2));
      last_acc = cyc;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(W + 1));
      ee = exp_err(a);
      er = (!wr && !ee) ? model[widx(a)] : 16'h0000;
      if (wr && !ee) model[widx(a)] = wd;
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(er));
      check("rsp_err", 32'(bus.rsp_err), 32'(ee));
      check("req_ready_busy", 32'(bus.req_ready), 0);
      held = bus.rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 1) bus.req_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
         check("hold_valid", 32'(bus.rsp_valid), 1);
         check("hold_rdata", 32'(bus.rsp_rdata), 32'(held));
         check("hold_ready", 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check("rsp_drop", 32'(bus.rsp_valid), 0);
      check("req_ready_back", 32'(bus.req_ready), 1);
   endtask

   initial begin
      logic [7:0] a;
      int h;
      int lat;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      clear_model();

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      @(negedge clk);
      reset = 1'b1;

      txn(1'b0, 8'h00, 16'h0000, 0, 1'b0, 1'b0);
      txn(1'b1, 8'h04, 16'hBEEF, 0, 1'b0, 1'b0);
      txn(1'b0, 8'h04, 16'h0000, 0, 1'b0, 1'b1);
      txn(1'b0, 8'h04, 16'h0000, 5, 1'b1, 1'b0);
      txn(1'b0, 8'h05, 16'h0000, 0, 1'b0, 1'b0);
      txn(1'b1, 8'h40, 16'hAAAA, 0, 1'b0, 1'b0);
      txn(1'b0, 8'h00, 16'h0000, 0, 1'b0, 1'b1);

      accept_req(1'b1, 8'h02, 16'h1234);
      #2 reset = 1'b0;
      #3;
      check("rst_wait_valid", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_wait_ready", 32'(bus.req_ready), 1);
      clear_model();
      txn(1'b0, 8'h02, 16'h0000, 0, 1'b0, 1'b0);

      txn(1'b1, 8'h06, 16'h5555, 0, 1'b0, 1'b0);
      accept_req(1'b0, 8'h06, 16'h0000);
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("resp_before_rst", 32'(bus.rsp_valid), 1);
      #2 reset = 1'b0;
      #3;
      check("rst_resp_valid", 32'(bus.rsp_valid), 0);
      check("rst_resp_rdata", 32'(bus.rsp_rdata), 0);
      @(negedge clk);
      reset = 1'b1;
      clear_model();
      txn(1'b0, 8'h06, 16'h0000, 0, 1'b0, 1'b0);

      prev_hold = 1;
      repeat (60) begin
         if ($urandom_range(0, 3) == 0) a = 8'($urandom);
         else a = 8'($urandom_range(0, 15) * 2);
         h = $urandom_range(0, 2);
         txn(1'($urandom), a, 16'($urandom), h, 1'b1, prev_hold == 0);
         prev_hold = h;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
